multi_cycle_control_unit: RTL and testbench

Multi-cycle control FSM that drives every control input of `multiCycleDatapath_code` (PCWrite, MemWrite, IRWrite, ImmSrc, RegWrite, ALUSrcA, AdrSrc, ALUControl, ALUSrcB, RegSrc, ResultSrc). It takes the instruction fields from the datapath instruction register and the datapath ALU_flags. It keeps the architectural NZCV flag register and evaluates condition codes. Together with the datapath it forms the complete multi-cycle CPU, replacing hand-sequenced control stimulus.

---
 rtl/multi_cycle_control_unit.sv | 218 +++++++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_control_unit
// Description : Moore control FSM for the multi-cycle datapath, with the NZCV
//               flag register and condition-code evaluation.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [3:0] Funct,
  input  logic       S,
  input  logic [3:0] ALU_flags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ImmSrc,
  output logic       ALUSrcA,
  output logic [1:0] AdrSrc,
  output logic [3:0] ALUControl,
  output logic [1:0] ALUSrcB,
  output logic [2:0] RegSrc,
  output logic [1:0] ResultSrc,
  output logic [3:0] State,
  output logic [3:0] Flags
);

  localparam logic [3:0] c_FETCH  = 4'd0;
  localparam logic [3:0] c_DECODE = 4'd1;
  localparam logic [3:0] c_EXEC   = 4'd2;
  localparam logic [3:0] c_ALUWB  = 4'd3;
  localparam logic [3:0] c_MEMADR = 4'd4;
  localparam logic [3:0] c_MEMRD  = 4'd5;
  localparam logic [3:0] c_MEMWB  = 4'd6;
  localparam logic [3:0] c_MEMWR  = 4'd7;
  localparam logic [3:0] c_LDIWB  = 4'd8;
  localparam logic [3:0] c_BRANCH = 4'd9;
  localparam logic [3:0] c_BIWR   = 4'd10;

  localparam logic [2:0] c_CLS_DP  = 3'd0;
  localparam logic [2:0] c_CLS_LDR = 3'd1;
  localparam logic [2:0] c_CLS_STR = 3'd2;
  localparam logic [2:0] c_CLS_LDI = 3'd3;
  localparam logic [2:0] c_CLS_B   = 3'd4;
  localparam logic [2:0] c_CLS_BL  = 3'd5;
  localparam logic [2:0] c_CLS_BI  = 3'd6;
  localparam logic [2:0] c_CLS_UND = 3'd7;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [3:0] w_out_state;
  logic [3:0] r_flags;
  logic [2:0] w_cls;
  logic       w_cond_ex;
  logic [2:0] w_regsrc;

  // Instruction class from the IR opcode/function fields
  always_comb begin
    w_cls = c_CLS_UND;
    case (Op)
      2'b00: if (Funct <= 4'b1010) w_cls = c_CLS_DP;
      2'b01: begin
        case (Funct[1:0])
          2'b00:   w_cls = c_CLS_LDR;
          2'b01:   w_cls = c_CLS_STR;
          2'b10:   w_cls = c_CLS_LDI;
          default: w_cls = c_CLS_UND;
        endcase
      end
      2'b10: begin
        case (Funct[1:0])
          2'b00:   w_cls = c_CLS_B;
          2'b01:   w_cls = c_CLS_BL;
          2'b10:   w_cls = c_CLS_BI;
          default: w_cls = c_CLS_UND;
        endcase
      end
      default: w_cls = c_CLS_UND;
    endcase
  end

  // Flags are {N,Z,C,V}
  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
      4'b0000: w_cond_ex =  r_flags[2];
      4'b0001: w_cond_ex = ~r_flags[2];
      4'b0010: w_cond_ex =  r_flags[1];
      4'b0011: w_cond_ex = ~r_flags[1];
      4'b0100: w_cond_ex =  r_flags[3];
      4'b0101: w_cond_ex = ~r_flags[3];
      4'b0110: w_cond_ex =  r_flags[0];
      4'b0111: w_cond_ex = ~r_flags[0];
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    w_regsrc = 3'b000;
    case (w_cls)
      c_CLS_DP, c_CLS_LDR, c_CLS_LDI: w_regsrc = 3'b100;
      c_CLS_STR:                      w_regsrc = 3'b110;
      c_CLS_BL:                       w_regsrc = 3'b001;
      c_CLS_BI:                       w_regsrc = 3'b101;
      default:                        w_regsrc = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_FETCH;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = c_FETCH;
    case (r_state)
      c_FETCH: w_next_state = c_DECODE;
      c_DECODE: begin
        if (!w_cond_ex) begin
          w_next_state = c_FETCH;
        end else begin
          case (w_cls)
            c_CLS_DP:             w_next_state = c_EXEC;
            c_CLS_LDR, c_CLS_STR: w_next_state = c_MEMADR;
            c_CLS_LDI:            w_next_state = c_LDIWB;
            c_CLS_B, c_CLS_BL:    w_next_state = c_BRANCH;
            c_CLS_BI:             w_next_state = c_BIWR;
            default:              w_next_state = c_FETCH;
          endcase
        end
      end
      c_EXEC:   w_next_state = c_ALUWB;
      c_MEMADR: w_next_state = (w_cls == c_CLS_STR) ? c_MEMWR : c_MEMRD;
      c_MEMRD:  w_next_state = c_MEMWB;
      default:  w_next_state = c_FETCH;
    endcase
  end

  // Flags capture the ALU result at the edge that ends EXEC
  always_ff @(posedge clk) begin
    if (rst)                        r_flags <= 4'b0000;
    else if (r_state == c_EXEC && S) r_flags <= ALU_flags;
  end

  // Reset presents FETCH controls with every write strobe suppressed
  assign w_out_state = rst ? c_FETCH : r_state;

  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ImmSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    AdrSrc     = 2'b00;
    ALUControl = 4'b0000;
    ALUSrcB    = 2'b00;
    RegSrc     = 3'b000;
    ResultSrc  = 2'b00;
    case (w_out_state)
      c_FETCH: begin
        PCWrite = 1'b1; IRWrite = 1'b1; ALUSrcA = 1'b1;
        ALUSrcB = 2'b10; ResultSrc = 2'b10; ImmSrc = 1'b1;
      end
      c_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; ImmSrc = 1'b1;
      end
      c_EXEC: begin
        ALUControl = Funct; ResultSrc = 2'b10;
      end
      c_ALUWB: begin
        ALUControl = Funct; RegWrite = 1'b1;
      end
      c_MEMADR: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10;
      end
      c_MEMRD: begin
        ALUSrcB = 2'b01; AdrSrc = 2'b01;
      end
      c_MEMWB: begin
        ALUSrcB = 2'b01; AdrSrc = 2'b01; ResultSrc = 2'b01; RegWrite = 1'b1;
      end
      c_MEMWR: begin
        ALUSrcB = 2'b01; AdrSrc = 2'b01; MemWrite = 1'b1;
      end
      c_LDIWB: begin
        ImmSrc = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b01;
        ResultSrc = 2'b11; RegWrite = 1'b1;
      end
      c_BRANCH: begin
        ImmSrc = 1'b1; PCWrite = 1'b1; ALUSrcB = 2'b01; ResultSrc = 2'b10;
        RegWrite = (w_cls == c_CLS_BL);
      end
      c_BIWR: begin
        ALUSrcA = 1'b1; ResultSrc = 2'b11; PCWrite = 1'b1;
      end
      default: begin
        ALUSrcA = 1'b0;
      end
    endcase
    if (w_out_state != c_FETCH) RegSrc = w_regsrc;
    if (rst) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign State = r_state;
  assign Flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_control_unit
// Description : Scoreboard bench for the multi-cycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multi_cycle_control_unit;

  localparam int DP = 0, LDR = 1, STR = 2, LDI = 3, B = 4, BL = 5, BI = 6, UND = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Cond, Funct, ALU_flags;
  logic [1:0] Op;
  logic       S;
  logic       PCWrite, MemWrite, IRWrite, RegWrite, ImmSrc, ALUSrcA;
  logic [1:0] AdrSrc, ALUSrcB, ResultSrc;
  logic [3:0] ALUControl, State, Flags;
  logic [2:0] RegSrc;

  multi_cycle_control_unit dut (
    .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .S(S),
    .ALU_flags(ALU_flags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .AdrSrc(AdrSrc), .ALUControl(ALUControl), .ALUSrcB(ALUSrcB),
    .RegSrc(RegSrc), .ResultSrc(ResultSrc), .State(State), .Flags(Flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic [3:0] flags;
    logic       pcw, memw, irw, regw, imm, srca;
    logic [1:0] adr;
    logic [3:0] aluc;
    logic [1:0] srcb;
    logic [2:0] regsrc;
    logic [1:0] res;
  } vec_t;

  typedef struct {
    vec_t v;
    bit   chk_regsrc;
    int   tag;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         tag_ctr = 0;
  logic [3:0] m_flags;
  vec_t       act;

  assign act = {State, Flags, PCWrite, MemWrite, IRWrite, RegWrite, ImmSrc, ALUSrcA,
                AdrSrc, ALUControl, ALUSrcB, RegSrc, ResultSrc};

  function automatic int classify(logic [1:0] op, logic [3:0] funct);
    if (op == 2'b00) return (funct <= 4'd10) ? DP : UND;
    if (op == 2'b01) return (funct[1:0] == 2'd0) ? LDR : (funct[1:0] == 2'd1) ? STR :
                            (funct[1:0] == 2'd2) ? LDI : UND;
    if (op == 2'b10) return (funct[1:0] == 2'd0) ? B : (funct[1:0] == 2'd1) ? BL :
                            (funct[1:0] == 2'd2) ? BI : UND;
    return UND;
  endfunction

  function automatic bit cond_pass(logic [3:0] c, logic [3:0] f);
    case (c)
      4'd0:  return f[2];
      4'd1:  return !f[2];
      4'd2:  return f[1];
      4'd3:  return !f[1];
      4'd4:  return f[3];
      4'd5:  return !f[3];
      4'd6:  return f[0];
      4'd7:  return !f[0];
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] regsrc_of(int cls);
    case (cls)
      DP, LDR, LDI: return 3'b100;
      STR:          return 3'b110;
      BL:           return 3'b001;
      BI:           return 3'b101;
      default:      return 3'b000;
    endcase
  endfunction

  // Expected Moore outputs for one state, straight from the control table
  function automatic vec_t st_out(int st, int cls, logic [3:0] funct, logic [3:0] flags);
    vec_t v;
    v = '0;
    v.state = st[3:0];
    v.flags = flags;
    case (st)
      0:  begin v.pcw = 1; v.irw = 1; v.srca = 1; v.srcb = 2; v.res = 2; v.imm = 1; end
      1:  begin v.srca = 1; v.srcb = 2; v.res = 2; v.imm = 1; end
      2:  begin v.aluc = funct; v.res = 2; end
      3:  begin v.aluc = funct; v.res = 0; v.regw = 1; end
      4:  begin v.srcb = 1; v.res = 2; end
      5:  begin v.srcb = 1; v.res = 0; v.adr = 1; end
      6:  begin v.srcb = 1; v.res = 1; v.adr = 1; v.regw = 1; end
      7:  begin v.srcb = 1; v.res = 0; v.adr = 1; v.memw = 1; end
      8:  begin v.imm = 1; v.srca = 1; v.srcb = 1; v.res = 3; v.regw = 1; end
      9:  begin v.imm = 1; v.pcw = 1; v.srcb = 1; v.res = 2; v.regw = (cls == BL); end
      10: begin v.srca = 1; v.srcb = 0; v.res = 3; v.pcw = 1; end
      default: v.state = st[3:0];
    endcase
    if (st != 0) v.regsrc = regsrc_of(cls);
    return v;
  endfunction

  // One instruction; rst_at picks the cycle that sees reset (-1 none),
  // exec_flags < 0 means random ALU flags during EXEC
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
                           input logic [3:0] funct, input bit s,
                           input int rst_at, input int exec_flags);
    int   cls;
    bit   cp;
    int   seq[$];
    exp_t e;
    cls = classify(op, funct);
    cp  = cond_pass(cond, m_flags);
    seq = '{0, 1};
    if (cp) begin
      case (cls)
        DP:      seq = '{0, 1, 2, 3};
        LDR:     seq = '{0, 1, 4, 5, 6};
        STR:     seq = '{0, 1, 4, 7};
        LDI:     seq = '{0, 1, 8};
        B, BL:   seq = '{0, 1, 9};
        BI:      seq = '{0, 1, 10};
        default: seq = '{0, 1};
      endcase
    end
    for (int k = 0; k < seq.size(); k++) begin
      @(posedge clk); #1;
      rst = (k == rst_at);
      ALU_flags = 4'($urandom);
      if (seq[k] == 2 && exec_flags >= 0) ALU_flags = exec_flags[3:0];
      if (k == 0) begin
        Cond = 4'($urandom); Op = 2'($urandom); Funct = 4'($urandom); S = 1'($urandom);
      end else begin
        Cond = cond; Op = op; Funct = funct; S = s;
      end
      tag_ctr++;
      e.tag = tag_ctr;
      if (rst) begin
        e.v = st_out(0, cls, funct, m_flags);
        e.v.pcw = 0;
        e.v.irw = 0;
        e.v.state = seq[k][3:0];
        e.chk_regsrc = 1'b1;
      end else begin
        e.v = st_out(seq[k], cls, funct, m_flags);
        e.chk_regsrc = (cls != UND) || (seq[k] == 0);
      end
      exp_q.push_back(e);
      if (rst) begin
        m_flags = 4'b0000;
        break;
      end
      if (seq[k] == 2 && s) m_flags = ALU_flags;
    end
  endtask

  // Monitor: one expected record per clock while the scoreboard holds any
  initial begin
    exp_t e;
    vec_t msk;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        msk = '1;
        if (!e.chk_regsrc) msk.regsrc = 3'b000;
        n_cmp++;
        if ((act & msk) !== (e.v & msk)) begin
          n_bad++;
          $display("FAIL cycle%0d: got state=%0d flags=%h vec=%h, want state=%0d flags=%h vec=%h",
                   e.tag, act.state, act.flags, act, e.v.state, e.v.flags, e.v);
        end
      end
    end
  end

  initial begin
    vec_t r;
    exp_t e;
    int   guard;
    rst = 1'b1; Cond = '0; Op = '0; Funct = '0; S = 1'b0; ALU_flags = '0;
    m_flags = 4'b0000;
    @(posedge clk); #1;
    r = st_out(0, UND, 4'd0, 4'd0);
    r.pcw = 0; r.irw = 0;
    e.v = r; e.chk_regsrc = 1'b1; e.tag = 0;
    exp_q.push_back(e);

    run_instr(4'b1110, 2'b00, 4'b0000, 1'b0, -1, -1);  // ADD
    run_instr(4'b1110, 2'b01, 4'b0000, 1'b0, -1, -1);  // LDR
    run_instr(4'b1110, 2'b01, 4'b0001, 1'b0, -1, -1);  // STR
    run_instr(4'b1110, 2'b00, 4'b0001, 1'b1, -1, 4);   // SUB S=1, flags 0100
    run_instr(4'b0000, 2'b10, 4'b0000, 1'b0, -1, -1);  // B EQ taken
    run_instr(4'b0001, 2'b10, 4'b0000, 1'b0, -1, -1);  // B NE not taken
    run_instr(4'b1110, 2'b10, 4'b0001, 1'b0, -1, -1);  // BL
    run_instr(4'b1110, 2'b10, 4'b0010, 1'b0, -1, -1);  // BI
    run_instr(4'b1110, 2'b01, 4'b0010, 1'b0, -1, -1);  // LDI
    run_instr(4'b1110, 2'b00, 4'b0010, 1'b1, -1, 15);  // AND sets flags 1111
    run_instr(4'b1110, 2'b01, 4'b0001, 1'b0, 3, -1);   // STR reset in MEMWR
    run_instr(4'b1110, 2'b00, 4'b1011, 1'b0, -1, -1);  // undefined ALU code
    run_instr(4'b1110, 2'b11, 4'b0000, 1'b0, -1, -1);  // undefined opcode
    run_instr(4'b1110, 2'b00, 4'b0011, 1'b1, 2, 7);    // reset in EXEC

    for (int i = 0; i < 400; i++) begin
      logic [3:0] c, f;
      logic [1:0] o;
      int         ra;
      c  = ($urandom_range(0, 1) == 0) ? 4'b1110 : 4'($urandom);
      o  = 2'($urandom);
      f  = (o == 2'b00 && $urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 10)) : 4'($urandom);
      ra = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(c, o, f, 1'($urandom), ra, -1);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d records left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
